// File: rtl/exu_seq_if.sv
// Execute-sequencer bus: decoder handshake, ALU select/result path and downstream handshake.
// The sequencer takes the slave side and its surroundings the master side.
interface exu_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [2:0]  in_func;
   logic [2:0]  in_brt;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic [31:0] in_imm;
   logic [31:0] in_pc;

   logic [1:0]  amux1;
   logic [1:0]  amux2;
   logic [2:0]  funcEU;
   logic [31:0] aluOut;

   // Latched operands feeding the shared execute datapath muxes
   logic [31:0] opr_src1;
   logic [31:0] opr_src2;
   logic [31:0] opr_imm;
   logic [31:0] opr_pc;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [31:0] out_npc;
   logic        out_redirect;
   logic        out_illegal;

   modport master (
      output in_valid, in_op, in_func, in_brt, in_src1, in_src2, in_imm, in_pc,
      input  in_ready,
      input  amux1, amux2, funcEU,
      output aluOut,
      input  opr_src1, opr_src2, opr_imm, opr_pc,
      input  out_valid, out_result, out_npc, out_redirect, out_illegal,
      output out_ready
   );

   modport slave (
      input  in_valid, in_op, in_func, in_brt, in_src1, in_src2, in_imm, in_pc,
      output in_ready,
      output amux1, amux2, funcEU,
      input  aluOut,
      output opr_src1, opr_src2, opr_imm, opr_pc,
      output out_valid, out_result, out_npc, out_redirect, out_illegal,
      input  out_ready
   );
endinterface

// File: rtl/exu_seq.sv
// Execute-stage sequencer: drives the shared ALU selects, two passes for branches.
// Latency 2 cycles (3 for branches) from accept; holds OUT until out_ready, in_ready only in IDLE.
module exu_seq #(
   parameter logic [2:0] FUNC_ADD  = 3'd0,
   parameter logic [2:0] FUNC_SUB  = 3'd1,
   parameter logic [2:0] FUNC_SLT  = 3'd2,
   parameter logic [2:0] FUNC_SLTU = 3'd3
) (
   input  logic      clk,
   input  logic      rst,
   exu_seq_if.slave  bus
);

   localparam logic [2:0] OP_RR     = 3'd0;
   localparam logic [2:0] OP_RI     = 3'd1;
   localparam logic [2:0] OP_AUIPC  = 3'd2;
   localparam logic [2:0] OP_LUI    = 3'd3;
   localparam logic [2:0] OP_BRANCH = 3'd4;
   localparam logic [2:0] OP_JAL    = 3'd5;
   localparam logic [2:0] OP_JALR   = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_EX1, S_EX2, S_OUT} state_t;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [2:0]  r_brt;
   logic [31:0] r_src1;
   logic [31:0] r_src2;
   logic [31:0] r_imm;
   logic [31:0] r_pc;
   logic        r_taken;
   logic        r_in_rdy;
   logic [1:0]  r_amux1;
   logic [1:0]  r_amux2;
   logic [2:0]  r_funcEU;
   logic        r_out_vld;
   logic [31:0] r_result;
   logic [31:0] r_npc;
   logic        r_redirect;
   logic        r_illegal;

   logic [1:0]  w_amux1;
   logic [1:0]  w_amux2;
   logic [2:0]  w_func;
   logic [31:0] w_pc4;
   logic        w_taken;
   logic        w_brt_bad;

   // EX1 selects are decoded from the incoming instruction so they are registered by the accept edge
   always_comb begin
      w_amux1 = 2'd0;
      w_amux2 = 2'd0;
      w_func  = FUNC_ADD;
      case (bus.in_op)
         OP_RR: begin
            w_amux1 = 2'd1;
            w_amux2 = 2'd1;
            w_func  = bus.in_func;
         end
         OP_RI: begin
            w_amux1 = 2'd1;
            w_amux2 = 2'd2;
            w_func  = bus.in_func;
         end
         OP_AUIPC, OP_JAL: begin
            w_amux1 = 2'd2;
            w_amux2 = 2'd2;
         end
         OP_LUI: begin
            w_amux2 = 2'd2;
         end
         OP_BRANCH: begin
            w_amux1 = 2'd1;
            w_amux2 = 2'd1;
            case (bus.in_brt)
               3'd4, 3'd5: w_func = FUNC_SLT;
               3'd6, 3'd7: w_func = FUNC_SLTU;
               default:    w_func = FUNC_SUB;
            endcase
         end
         OP_JALR: begin
            w_amux1 = 2'd1;
            w_amux2 = 2'd2;
         end
         default: begin
            w_amux1 = 2'd0;
            w_amux2 = 2'd0;
         end
      endcase
   end

   assign w_pc4     = r_pc + 32'd4;
   assign w_brt_bad = (r_brt == 3'd2) || (r_brt == 3'd3);

   always_comb begin
      w_taken = 1'b0;
      case (r_brt)
         3'd0:       w_taken = (bus.aluOut == 32'd0);
         3'd1:       w_taken = (bus.aluOut != 32'd0);
         3'd4, 3'd6: w_taken = bus.aluOut[0];
         3'd5, 3'd7: w_taken = !bus.aluOut[0];
         default:    w_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_op       <= 3'd0;
         r_brt      <= 3'd0;
         r_src1     <= 32'd0;
         r_src2     <= 32'd0;
         r_imm      <= 32'd0;
         r_pc       <= 32'd0;
         r_taken    <= 1'b0;
         r_in_rdy   <= 1'b1;
         r_amux1    <= 2'd0;
         r_amux2    <= 2'd0;
         r_funcEU   <= FUNC_ADD;
         r_out_vld  <= 1'b0;
         r_result   <= 32'd0;
         r_npc      <= 32'd0;
         r_redirect <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_op     <= bus.in_op;
                  r_brt    <= bus.in_brt;
                  r_src1   <= bus.in_src1;
                  r_src2   <= bus.in_src2;
                  r_imm    <= bus.in_imm;
                  r_pc     <= bus.in_pc;
                  r_in_rdy <= 1'b0;
                  r_amux1  <= w_amux1;
                  r_amux2  <= w_amux2;
                  r_funcEU <= w_func;
                  r_state  <= S_EX1;
               end
            end
            S_EX1: begin
               r_amux1   <= 2'd0;
               r_amux2   <= 2'd0;
               r_funcEU  <= FUNC_ADD;
               r_out_vld <= 1'b1;
               r_state   <= S_OUT;
               r_illegal <= 1'b0;
               case (r_op)
                  OP_RR, OP_RI, OP_AUIPC, OP_LUI: begin
                     r_result   <= bus.aluOut;
                     r_npc      <= w_pc4;
                     r_redirect <= 1'b0;
                  end
                  OP_JAL: begin
                     r_result   <= w_pc4;
                     r_npc      <= bus.aluOut;
                     r_redirect <= 1'b1;
                  end
                  OP_JALR: begin
                     r_result   <= w_pc4;
                     r_npc      <= bus.aluOut & ~32'd1;
                     r_redirect <= 1'b1;
                  end
                  OP_BRANCH: begin
                     r_result   <= 32'd0;
                     r_npc      <= w_pc4;
                     r_redirect <= 1'b0;
                     if (w_brt_bad) begin
                        r_illegal <= 1'b1;
                     end else begin
                        // Second pass reuses the ALU for pc+imm; result waits until EX2
                        r_taken   <= w_taken;
                        r_amux1   <= 2'd2;
                        r_amux2   <= 2'd2;
                        r_out_vld <= 1'b0;
                        r_state   <= S_EX2;
                     end
                  end
                  default: begin
                     r_result   <= 32'd0;
                     r_npc      <= w_pc4;
                     r_redirect <= 1'b0;
                     r_illegal  <= 1'b1;
                  end
               endcase
            end
            S_EX2: begin
               r_amux1    <= 2'd0;
               r_amux2    <= 2'd0;
               r_funcEU   <= FUNC_ADD;
               r_result   <= 32'd0;
               r_npc      <= r_taken ? bus.aluOut : w_pc4;
               r_redirect <= r_taken;
               r_out_vld  <= 1'b1;
               r_state    <= S_OUT;
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  r_out_vld <= 1'b0;
                  r_in_rdy  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_rdy;
   assign bus.amux1        = r_amux1;
   assign bus.amux2        = r_amux2;
   assign bus.funcEU       = r_funcEU;
   assign bus.opr_src1     = r_src1;
   assign bus.opr_src2     = r_src2;
   assign bus.opr_imm      = r_imm;
   assign bus.opr_pc       = r_pc;
   assign bus.out_valid    = r_out_vld;
   assign bus.out_result   = r_result;
   assign bus.out_npc      = r_npc;
   assign bus.out_redirect = r_redirect;
   assign bus.out_illegal  = r_illegal;

endmodule

// File: tb/tb_exu_seq.sv
// Directed bench for exu_seq with a behavioural ALU built from the driven operands.
module tb_exu_seq;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   logic [31:0] m_src1, m_src2, m_imm, m_pc;
   logic [31:0] m_a, m_b;

   exu_seq_if bus ();

   exu_seq u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      m_a = (bus.amux1 == 2'd1) ? m_src1 : (bus.amux1 == 2'd2) ? m_pc : 32'd0;
      m_b = (bus.amux2 == 2'd1) ? m_src2 : (bus.amux2 == 2'd2) ? m_imm : 32'd0;
      case (bus.funcEU)
         3'd0:    bus.aluOut = m_a + m_b;
         3'd1:    bus.aluOut = m_a - m_b;
         3'd2:    bus.aluOut = {31'd0, $signed(m_a) < $signed(m_b)};
         3'd3:    bus.aluOut = {31'd0, m_a < m_b};
         default: bus.aluOut = 32'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // sel packs {amux1, amux2, funcEU}; a negative sel skips the EX1 select check
   task automatic run(input string name, input logic [2:0] op, input logic [2:0] func,
                      input logic [2:0] brt, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] imm, input logic [31:0] pc, input int sel,
                      input logic [31:0] e_res, input logic [31:0] e_npc, input logic e_red,
                      input logic e_ill, input int e_lat, input int hold);
      int lat;
      lat = 0;
      @(negedge clk);
      check({name, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      m_src1 = s1; m_src2 = s2; m_imm = imm; m_pc = pc;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_func = func; bus.in_brt = brt;
      bus.in_src1 = s1; bus.in_src2 = s2; bus.in_imm = imm; bus.in_pc = pc;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (lat == 1 && sel >= 0)
            check({name, ".ex1_sel"}, {25'd0, bus.amux1, bus.amux2, bus.funcEU}, sel[31:0]);
         if (lat == 2 && e_lat == 3)
            check({name, ".ex2_sel"}, {25'd0, bus.amux1, bus.amux2, bus.funcEU}, 32'h50);
         if (bus.out_valid) break;
      end
      check({name, ".latency"}, lat, e_lat);
      check({name, ".result"}, bus.out_result, e_res);
      check({name, ".npc"}, bus.out_npc, e_npc);
      check({name, ".redirect"}, {31'd0, bus.out_redirect}, {31'd0, e_red});
      check({name, ".illegal"}, {31'd0, bus.out_illegal}, {31'd0, e_ill});
      check({name, ".out_sel"}, {25'd0, bus.amux1, bus.amux2, bus.funcEU}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({name, ".hold_vld"}, {31'd0, bus.out_valid}, 32'd1);
         check({name, ".hold_rdy"}, {31'd0, bus.in_ready}, 32'd0);
         check({name, ".hold_npc"}, bus.out_npc, e_npc);
         check({name, ".hold_res"}, bus.out_result, e_res);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check({name, ".done_vld"}, {31'd0, bus.out_valid}, 32'd0);
      check({name, ".done_rdy"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      m_src1 = 0; m_src2 = 0; m_imm = 0; m_pc = 0;
      bus.in_valid = 0; bus.in_op = 0; bus.in_func = 0; bus.in_brt = 0;
      bus.in_src1 = 0; bus.in_src2 = 0; bus.in_imm = 0; bus.in_pc = 0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst.npc", bus.out_npc, 32'd0);

      //   name       op    fn    brt   src1          src2          imm           pc            sel    res           npc           red ill lat hold
      run("rr_add",   3'd0, 3'd0, 3'd0, 32'd5,        32'd7,        32'd0,        32'h100,      'h28,  32'd12,       32'h104,      0, 0, 2, 0);
      run("ri_sub",   3'd1, 3'd1, 3'd0, 32'd10,       32'd0,        32'd3,        32'h200,      'h31,  32'd7,        32'h204,      0, 0, 2, 0);
      run("ri_slt",   3'd1, 3'd2, 3'd0, 32'hFFFFFFFF, 32'd0,        32'd1,        32'h300,      'h32,  32'd1,        32'h304,      0, 0, 2, 0);
      run("auipc",    3'd2, 3'd0, 3'd0, 32'd0,        32'd0,        32'h5000,     32'h1000,     'h50,  32'h6000,     32'h1004,     0, 0, 2, 0);
      run("lui_wrap", 3'd3, 3'd0, 3'd0, 32'd9,        32'd0,        32'hABCD0000, 32'hFFFFFFFC, 'h10,  32'hABCD0000, 32'h0,        0, 0, 2, 0);
      run("jal",      3'd5, 3'd0, 3'd0, 32'd0,        32'd0,        32'h40,       32'h400,      'h50,  32'h404,      32'h440,      1, 0, 2, 0);
      run("jalr_bp",  3'd6, 3'd0, 3'd0, 32'h80000101, 32'd0,        32'd2,        32'h80000000, 'h30,  32'h80000004, 32'h80000102, 1, 0, 2, 5);
      run("beq_tk",   3'd4, 3'd0, 3'd0, 32'h10,       32'h10,       32'h20,       32'h80000000, 'h29,  32'd0,        32'h80000020, 1, 0, 3, 0);
      run("bltu_nt",  3'd4, 3'd0, 3'd6, 32'hFFFFFFFF, 32'd1,        32'h100,      32'h500,      'h2B,  32'd0,        32'h504,      0, 0, 3, 0);
      run("bge_tk",   3'd4, 3'd0, 3'd5, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFF0, 32'h600,      'h2A,  32'd0,        32'h5F0,      1, 0, 3, 0);
      run("bne_nt",   3'd4, 3'd0, 3'd1, 32'd3,        32'd3,        32'h80,       32'h700,      'h29,  32'd0,        32'h704,      0, 0, 3, 0);
      run("ill_op",   3'd7, 3'd0, 3'd0, 32'd1,        32'd2,        32'd3,        32'h800,      'h00,  32'd0,        32'h804,      0, 1, 2, 0);
      run("ill_brt",  3'd4, 3'd0, 3'd2, 32'd1,        32'd2,        32'h40,       32'h900,      -1,    32'd0,        32'h904,      0, 1, 2, 0);
      run("rr_after", 3'd0, 3'd1, 3'd0, 32'd3,        32'd5,        32'd0,        32'hA00,      'h29,  32'hFFFFFFFE, 32'hA04,      0, 0, 2, 0);

      // Reset during EX1 of an RR op abandons it and clears the previous outputs
      @(negedge clk);
      m_src1 = 32'd5; m_src2 = 32'd7; m_pc = 32'hB00;
      bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_func = 3'd0;
      bus.in_src1 = 32'd5; bus.in_src2 = 32'd7; bus.in_pc = 32'hB00;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("midrst.result", bus.out_result, 32'd0);
      check("midrst.npc", bus.out_npc, 32'd0);
      check("midrst.flags", {30'd0, bus.out_redirect, bus.out_illegal}, 32'd0);
      check("midrst.sel", {25'd0, bus.amux1, bus.amux2, bus.funcEU}, 32'd0);
      repeat (3) @(negedge clk);
      check("midrst.no_out", {31'd0, bus.out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exu_seq.md
Name: exu_seq

Overview:
- Execute-stage sequencer for the NPC core. It sits between the decoder and the LSU/WBU stages and uses valid/ready handshakes on both sides.
- It latches one decoded instruction and drives the operand-mux selects and ALU function of the shared execute datapath.
- It registers the ALU result. Conditional branches use the single ALU twice: pass 1 compares, pass 2 computes the target. It then presents result and next-PC downstream.

Parameters:
- FUNC_ADD, 3'd0, ALU function code for add
- FUNC_SUB, 3'd1, ALU function code for subtract
- FUNC_SLT, 3'd2, ALU function code for signed set-less-than
- FUNC_SLTU, 3'd3, ALU function code for unsigned set-less-than

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoder offers instruction
- in_ready  out  1  sequencer accepts instruction
- in_op  in  3  class: 0 RR, 1 RI, 2 AUIPC, 3 LUI, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal
- in_func  in  3  ALU function for RR/RI
- in_brt  in  3  branch funct3
- in_src1, in_src2, in_imm, in_pc  in  32 each  operands
- amux1  out  2  ALU src1 select: 0 zero, 1 src1, 2 pc
- amux2  out  2  ALU src2 select: 0 zero, 1 src2, 2 imm
- funcEU  out  3  ALU function
- aluOut  in  32  ALU result (combinational from selects)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_result  out  32  writeback value
- out_npc  out  32  next PC
- out_redirect  out  1  control transfer taken
- out_illegal  out  1  illegal op/branch type

Behaviour:
- States: IDLE, EX1, EX2, OUT.
- Reset (synchronous, rst high at a rising edge):
  - state=IDLE, out_valid=0.
  - out_result, out_npc, out_redirect, out_illegal all 0.
  - Latched operands are cleared.
  - Reset mid-operation abandons the instruction; no output is produced.
- in_ready=1 only in IDLE. in_valid is ignored in other states.
- Accept: in_valid&&in_ready in IDLE latches all in_* and moves to EX1.
- IDLE and OUT: amux1=0, amux2=0, funcEU=FUNC_ADD (ALU quiescent).
- EX1 selects, per latched op:
  - RR: (1,1,in_func).
  - RI: (1,2,in_func).
  - AUIPC: (2,2,ADD).
  - LUI: (0,2,ADD).
  - BRANCH: (1,1,cmp), where cmp = SUB for BEQ(0)/BNE(1), SLT for BLT(4)/BGE(5), SLTU for BLTU(6)/BGEU(7).
  - JAL: (2,2,ADD).
  - JALR: (1,2,ADD).
  - Illegal: (0,0,ADD).
- EX1 result registration:
  - Non-branch ops: register out_result, out_npc, out_redirect, go to OUT.
  - BRANCH: register taken flag, go to EX2.
- Branch taken flag:
  - BEQ: aluOut==0. BNE: aluOut!=0.
  - BLT and BLTU: aluOut[0]. BGE and BGEU: !aluOut[0].
  - in_brt 2 or 3: illegal. Skip EX2, go to OUT.
- EX2: selects (2,2,ADD). Register target=aluOut, go to OUT.
- Outputs per op:
  - RR/RI/AUIPC/LUI: out_result=aluOut, out_npc=pc+4, out_redirect=0.
  - JAL: out_result=pc+4, out_npc=aluOut, out_redirect=1.
  - JALR: out_result=pc+4, out_npc=aluOut&~1, out_redirect=1.
  - BRANCH taken: out_result=0, out_npc=target, out_redirect=1.
  - BRANCH not taken: out_result=0, out_npc=pc+4, out_redirect=0.
  - Illegal: out_illegal=1, out_result=0, out_npc=pc+4, out_redirect=0.
- pc+4 comes from a dedicated incrementer, not the ALU. All additions are 32-bit and wrap modulo 2^32.
- OUT: out_valid=1 and outputs stay stable until out_ready. On out_valid&&out_ready, go to IDLE and out_valid falls next cycle.
- Latency from accept edge to out_valid high: 2 cycles for single-pass ops, 3 for branches.
- Throughput: at most one instruction per 3 cycles (single-pass) or 4 cycles (branch).
- out_ready held low: stay in OUT indefinitely; in_ready stays 0.

Test Plan:
- Reset: hold rst 2 cycles during EX1 of an RR op -> state IDLE, out_valid 0, in_ready 1, all outputs 0.
- RR add: src1=5, src2=7, func=ADD, out_ready=1 -> EX1 selects (1,1,0); out_valid 2 cycles after accept; out_result=12, out_npc=pc+4, out_redirect=0.
- BEQ taken: src1=src2=0x10, pc=0x80000000, imm=0x20 -> EX1 funcEU=SUB, EX2 selects (2,2,ADD); out_npc=0x80000020, out_redirect=1, out_result=0, latency 3.
- BLTU not taken and BGE taken:
  - BLTU with src1=0xFFFFFFFF, src2=1 -> out_redirect=0, out_npc=pc+4.
  - BGE with src1=1, src2=0xFFFFFFFF -> out_redirect=1.
- JALR backpressure: src1=0x80000101, imm=2, pc=0x80000000, out_ready low 5 cycles -> outputs stable, in_ready 0; out_npc=0x80000102, out_result=0x80000004; accept on out_ready, in_ready returns 1 next cycle.
- Illegal op and brt: in_op=7, then BRANCH with brt=2 -> out_illegal=1, out_npc=pc+4, out_redirect=0, no EX2 cycle.
